mac_array_v2: RTL and testbench

MAC_ARRAY_V2 -- requirements
Module: mac_array_v2

---
 rtl/mac_array_v2.sv | 162 ++++++++++++++++
 tb/tb_mac_array_v2.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_v2.sv
// ROW-deep multiply-add pipeline over COLUMN output channels, followed by an
// optional per-column frame accumulator and a saturating output register.
module mac_array_v2 #(
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int CW     = 19,
    parameter int ACCB   = 8,
    parameter int OW     = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROW*DW-1:0]        m_data,
    input  logic                     m_first,
    input  logic                     m_last,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [COLUMN*CW-1:0]     ci,
    input  logic                     w_we,
    input  logic [$clog2(ROW)-1:0]   w_addr,
    input  logic [COLUMN*WW-1:0]     w_data,
    input  logic                     acc_mode,
    output logic [COLUMN*OW-1:0]     s_data,
    output logic [COLUMN-1:0]        s_sat,
    output logic                     s_first,
    output logic                     s_last,
    output logic                     s_valid,
    input  logic                     s_ready,
    output logic                     busy,
    output logic                     w_err,
    input  logic                     w_err_clr
);
    localparam int AW = CW + ACCB;
    localparam int PW = DW + WW;

    logic                            advance;
    logic                            acc_open;
    logic [ROW-1:0][COLUMN*WW-1:0]   wgt;
    logic [ROW-1:0]                  vld_pipe, fst_pipe, lst_pipe;
    logic [ROW-2:0][ROW*DW-1:0]      x_pipe;
    logic [ROW-1:0][COLUMN*CW-1:0]   p_pipe;
    logic [ROW-1:0]                  v_in, f_in, l_in;
    logic [ROW-1:0][ROW*DW-1:0]      x_in;
    logic [ROW-1:0][COLUMN*CW-1:0]   p_in, p_nxt;
    logic [COLUMN-1:0][AW-1:0]       acc, acc_nxt;
    logic [COLUMN*OW-1:0]            sat_data;
    logic [COLUMN-1:0]               sat_flag;
    logic                            top_v, top_f, top_l, emit;
    logic                            unused_x;

    assign advance = !s_valid || s_ready;
    assign m_ready = advance;
    assign busy    = (|vld_pipe) || s_valid || acc_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wgt <= '0;
        else if (w_we && !busy)
            wgt[w_addr] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            w_err <= 1'b0;
        else if (w_we && busy)
            w_err <= 1'b1;
        else if (w_err_clr)
            w_err <= 1'b0;
    end

    // Each stage consumes the lowest activation and shifts the rest down,
    // so stage r always finds its own x in bits [DW-1:0].
    for (genvar r = 0; r < ROW; r++) begin : g_row
        if (r == 0) begin : g_head
            assign x_in[r] = m_data;
            assign p_in[r] = ci;
            assign v_in[r] = m_valid;
            assign f_in[r] = m_first;
            assign l_in[r] = m_last;
        end else begin : g_tail
            assign x_in[r] = x_pipe[r-1];
            assign p_in[r] = p_pipe[r-1];
            assign v_in[r] = vld_pipe[r-1];
            assign f_in[r] = fst_pipe[r-1];
            assign l_in[r] = lst_pipe[r-1];
        end
        for (genvar c = 0; c < COLUMN; c++) begin : g_col
            logic signed [DW-1:0] xv;
            logic signed [WW-1:0] wv;
            logic signed [PW-1:0] xe, we, prod;
            assign xv   = x_in[r][DW-1:0];
            assign wv   = wgt[r][c*WW +: WW];
            assign xe   = {{WW{xv[DW-1]}}, xv};
            assign we   = {{DW{wv[WW-1]}}, wv};
            assign prod = xe * we;
            assign p_nxt[r][c*CW +: CW] = p_in[r][c*CW +: CW] + {{(CW-PW){prod[PW-1]}}, prod};
        end
    end

    assign unused_x = ^x_in[ROW-1][ROW*DW-1:DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            fst_pipe <= '0;
            lst_pipe <= '0;
            x_pipe   <= '0;
            p_pipe   <= '0;
        end else if (advance) begin
            vld_pipe <= v_in;
            fst_pipe <= f_in;
            lst_pipe <= l_in;
            p_pipe   <= p_nxt;
            for (int r = 0; r < ROW-1; r++)
                x_pipe[r] <= x_in[r] >> DW;
        end
    end

    assign top_v = vld_pipe[ROW-1];
    assign top_f = fst_pipe[ROW-1];
    assign top_l = lst_pipe[ROW-1];
    assign emit  = top_v && (!acc_mode || top_l);

    for (genvar c = 0; c < COLUMN; c++) begin : g_out
        logic [AW-1:0] sum_ext;
        logic          ovf;
        assign sum_ext    = {{ACCB{p_pipe[ROW-1][c*CW+CW-1]}}, p_pipe[ROW-1][c*CW +: CW]};
        assign acc_nxt[c] = (!acc_mode || top_f) ? sum_ext : acc[c] + sum_ext;
        // Out of range when the bits above the output sign are not all sign copies.
        assign ovf         = acc_nxt[c][AW-1:OW-1] != {(AW-OW+1){acc_nxt[c][AW-1]}};
        assign sat_flag[c] = ovf;
        assign sat_data[c*OW +: OW] = !ovf             ? acc_nxt[c][OW-1:0] :
                                      acc_nxt[c][AW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                                         {1'b0, {(OW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid  <= 1'b0;
            s_data   <= '0;
            s_sat    <= '0;
            s_first  <= 1'b0;
            s_last   <= 1'b0;
            acc      <= '0;
            acc_open <= 1'b0;
        end else if (advance) begin
            s_valid <= emit;
            if (emit) begin
                s_data  <= sat_data;
                s_sat   <= sat_flag;
                s_first <= acc_mode | top_f;
                s_last  <= acc_mode | top_l;
            end
            if (top_v && acc_mode) begin
                acc      <= top_l ? '0 : acc_nxt;
                acc_open <= !top_l;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_v2.sv
// Directed bench for mac_array_v2 with an integer reference model and
// an every-cycle output scoreboard.
module tb_mac_array_v2;
    localparam int DW = 8, WW = 8, ROW = 8, COLUMN = 6, CW = 19, ACCB = 8, OW = 22;
    localparam int AW = CW + ACCB;
    localparam int AB = $clog2(ROW);

    logic                    clk = 1'b0, rst_n = 1'b0;
    logic [ROW*DW-1:0]       m_data;
    logic                    m_first, m_last, m_valid, m_ready;
    logic [COLUMN*CW-1:0]    ci;
    logic                    w_we;
    logic [AB-1:0]           w_addr;
    logic [COLUMN*WW-1:0]    w_data;
    logic                    acc_mode;
    logic [COLUMN*OW-1:0]    s_data;
    logic [COLUMN-1:0]       s_sat;
    logic                    s_first, s_last, s_valid, s_ready;
    logic                    busy, w_err, w_err_clr;

    mac_array_v2 #(.DW(DW), .WW(WW), .ROW(ROW), .COLUMN(COLUMN), .CW(CW), .ACCB(ACCB), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .m_data(m_data), .m_first(m_first), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .ci(ci), .w_we(w_we), .w_addr(w_addr),
        .w_data(w_data), .acc_mode(acc_mode), .s_data(s_data), .s_sat(s_sat),
        .s_first(s_first), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .w_err(w_err), .w_err_clr(w_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [COLUMN*OW-1:0] d;
        logic [COLUMN-1:0]    sat;
        logic                 f, l;
        int                   cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   le;
    int     checks = 0, errors = 0, cyc = 0;
    bit     chk_lat = 1'b1, fresh = 1'b1;
    int     mw[ROW][COLUMN];
    longint macc[COLUMN];
    int     n0;

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m[w-1]) m = m - (longint'(1) << w);
        return m;
    endfunction

    // Reference: plain signed dot product per column, then frame accumulation and clamp.
    task automatic model_accept();
        exp_t                 e;
        longint               s, lim;
        logic [COLUMN*OW-1:0] d;
        logic [COLUMN-1:0]    st;
        lim = longint'(1) << (OW-1);
        for (int c = 0; c < COLUMN; c++) begin
            s = $signed(ci[c*CW +: CW]);
            for (int r = 0; r < ROW; r++)
                s += longint'($signed(m_data[r*DW +: DW])) * mw[r][c];
            s = wrap(s, CW);
            if (acc_mode) begin
                macc[c] = m_first ? s : wrap(macc[c] + s, AW);
                s = macc[c];
                if (m_last) macc[c] = 0;
            end
            st[c] = 1'b1;
            if (s > lim - 1)   s = lim - 1;
            else if (s < -lim) s = -lim;
            else               st[c] = 1'b0;
            d[c*OW +: OW] = s[OW-1:0];
        end
        if (!acc_mode || m_last) begin
            e.d   = d;
            e.sat = st;
            e.f   = acc_mode ? 1'b1 : m_first;
            e.l   = acc_mode ? 1'b1 : m_last;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (s_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got s_valid=1 data=%h want no output", s_data);
                end else begin
                    checks++;
                    if ({s_data, s_sat, s_first, s_last} !==
                        {exp_q[0].d, exp_q[0].sat, exp_q[0].f, exp_q[0].l}) begin
                        errors++;
                        $display("FAIL out_data: got %h sat %b f%b l%b want %h sat %b f%b l%b",
                                 s_data, s_sat, s_first, s_last,
                                 exp_q[0].d, exp_q[0].sat, exp_q[0].f, exp_q[0].l);
                    end
                    if (fresh && chk_lat) check("latency", cyc - exp_q[0].cyc, ROW + 1);
                    fresh = 1'b0;
                    if (s_ready) begin
                        void'(exp_q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
            if (m_valid && m_ready) model_accept();
        end
    end

    function automatic logic [ROW*DW-1:0] xall(input int v);
        logic [ROW*DW-1:0] x;
        for (int r = 0; r < ROW; r++) x[r*DW +: DW] = v[DW-1:0];
        return x;
    endfunction

    function automatic logic [ROW*DW-1:0] x100();
        logic [ROW*DW-1:0] x;
        int v;
        for (int r = 0; r < ROW; r++) begin
            v = (r < 6) ? 10 : 20;
            x[r*DW +: DW] = v[DW-1:0];
        end
        return x;
    endfunction

    function automatic logic [COLUMN*CW-1:0] cistep(input int base, input int k);
        logic [COLUMN*CW-1:0] v;
        int t;
        for (int c = 0; c < COLUMN; c++) begin
            t = base + c * k;
            v[c*CW +: CW] = t[CW-1:0];
        end
        return v;
    endfunction

    task automatic wr_row(input int r, input int base, input int sc, input bit apply, input bit clr);
        int t;
        w_addr = r[AB-1:0];
        for (int c = 0; c < COLUMN; c++) begin
            t = base + sc * c;
            w_data[c*WW +: WW] = t[WW-1:0];
        end
        w_we = 1'b1;
        w_err_clr = clr;
        @(posedge clk); #1;
        w_we = 1'b0;
        w_err_clr = 1'b0;
        if (apply)
            for (int c = 0; c < COLUMN; c++) mw[r][c] = int'(wrap(base + sc * c, WW));
    endtask

    task automatic set_w(input int base, input int sr, input int sc);
        for (int r = 0; r < ROW; r++) wr_row(r, base + r * sr, sc, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [ROW*DW-1:0] x, input logic [COLUMN*CW-1:0] c, input bit f, input bit l);
        int n = 0;
        m_data = x; ci = c; m_first = f; m_last = l; m_valid = 1'b1;
        @(negedge clk);
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got m_ready=0 want 1");
        end
        @(posedge clk); #1;
        m_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        s_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic last_exp();
        le = exp_q[exp_q.size()-1];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_data = '0; m_first = 0; m_last = 0; m_valid = 0; ci = '0;
        w_we = 0; w_addr = '0; w_data = '0; acc_mode = 0; s_ready = 1; w_err_clr = 0;
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COLUMN; c++) mw[r][c] = 0;
        for (int c = 0; c < COLUMN; c++) macc[c] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init_m_ready", m_ready, 1);
        check("init_s_valid", s_valid, 0);
        check("init_busy", busy, 0);
        check("init_w_err", w_err, 0);
        @(posedge clk); #1;

        // Pass mode, uniform weights.
        set_w(1, 0, 0);
        send(xall(2), '0, 1'b1, 1'b1);
        last_exp();
        check("model_pass16_c0", $signed(le.d[0 +: OW]), 16);
        check("model_pass16_c5", $signed(le.d[5*OW +: OW]), 16);
        wait_idle();

        // Pass mode, per-row/per-column weights, mixed signs, bias, varied flags.
        set_w(-3, 1, 2);
        send(xall(1), '0, 1'b0, 1'b1);
        last_exp();
        check("model_mixed_c5", $signed(le.d[5*OW +: OW]), 84);
        send(xall(-7), cistep(-2500, 1000), 1'b1, 1'b0);
        send(xall(13), cistep(300, -77), 1'b0, 1'b0);
        send(x100(), cistep(5, 5), 1'b1, 1'b1);
        wait_idle();

        // Signed extremes.
        set_w(-128, 0, 0);
        send(xall(-128), cistep(0, 1), 1'b1, 1'b1);
        last_exp();
        check("model_ext_c5", $signed(le.d[5*OW +: OW]), 131077);
        check("model_ext_sat", le.sat, 0);
        wait_idle();

        // Accumulate: 3-beat frame, single-beat frame, then a short frame.
        acc_mode = 1'b1;
        set_w(1, 0, 0);
        n0 = exp_q.size();
        send(x100(), '0, 1'b1, 1'b0);
        send(x100(), '0, 1'b0, 1'b0);
        check("acc_no_mid_out", exp_q.size(), n0);
        send(x100(), '0, 1'b0, 1'b1);
        check("acc_one_out", exp_q.size(), n0 + 1);
        last_exp();
        check("model_acc300", $signed(le.d[0 +: OW]), 300);
        send(x100(), '0, 1'b1, 1'b1);
        last_exp();
        check("model_acc_single", $signed(le.d[3*OW +: OW]), 100);
        send(xall(2), '0, 1'b1, 1'b0);
        send(xall(2), cistep(1, 1), 1'b0, 1'b1);
        wait_idle();

        // Saturation both ways.
        set_w(-128, 0, 0);
        for (int i = 0; i < 40; i++) send(xall(-128), '0, i == 0, i == 39);
        last_exp();
        check("model_sat_pos", $signed(le.d[2*OW +: OW]), 2097151);
        check("model_sat_pos_flag", le.sat, 6'h3f);
        for (int i = 0; i < 40; i++) send(xall(0), cistep(-131072, 0), i == 0, i == 39);
        last_exp();
        check("model_sat_neg", $signed(le.d[4*OW +: OW]), -2097152);
        wait_idle();

        // Stall with a full pipeline, and weight writes while busy.
        acc_mode = 1'b0;
        set_w(1, 0, 1);
        chk_lat = 1'b0;
        s_ready = 1'b0;
        for (int i = 0; i < ROW + 1; i++) send(xall(i + 1), cistep(i, 3), i[0], 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("stall_m_ready", m_ready, 0);
            check("stall_s_valid", s_valid, 1);
        end
        @(posedge clk); #1;
        check("w_err_before", w_err, 0);
        wr_row(3, 55, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("w_err_set", w_err, 1);
        @(posedge clk); #1;
        wr_row(5, 77, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("w_err_set_wins", w_err, 1);
        @(posedge clk); #1;
        wait_idle();
        check("w_err_sticky", w_err, 1);
        w_err_clr = 1'b1;
        @(posedge clk); #1;
        w_err_clr = 1'b0;
        @(negedge clk);
        check("w_err_cleared", w_err, 0);
        @(posedge clk); #1;
        chk_lat = 1'b1;
        send(xall(1), '0, 1'b1, 1'b1);
        last_exp();
        check("model_w_kept_c5", $signed(le.d[5*OW +: OW]), 48);
        wait_idle();

        // Reset in the middle of an open accumulation with w_err set.
        acc_mode = 1'b1;
        set_w(2, 0, 0);
        send(xall(1), '0, 1'b1, 1'b1);
        wait_idle();
        send(xall(3), '0, 1'b1, 1'b0);
        wr_row(0, 9, 0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("open_frame_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_s_valid", s_valid, 0);
        check("rst_s_data_zero", s_data == '0, 1);
        check("rst_s_sat", s_sat, 0);
        check("rst_s_first", s_first, 0);
        check("rst_s_last", s_last, 0);
        check("rst_busy", busy, 0);
        check("rst_w_err", w_err, 0);
        exp_q.delete();
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COLUMN; c++) mw[r][c] = 0;
        for (int c = 0; c < COLUMN; c++) macc[c] = 0;
        fresh = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_m_ready", m_ready, 1);
        check("post_rst_s_valid", s_valid, 0);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;
        send(xall(5), cistep(0, 3), 1'b0, 1'b1);
        last_exp();
        check("model_post_rst_c5", $signed(le.d[5*OW +: OW]), 15);
        wait_idle();
        acc_mode = 1'b0;

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
